// File: rtl/md_scoreboard.sv
// md_scoreboard: fixed-latency multdiv tracker with completion queue, hazards and optional forwarding (MD_SCOREBOARD_FWD_EN)
module md_scoreboard #(
    parameter int STAGES = 16,
    parameter int DATA_W = 32,
    parameter int QDEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic              issue_is_div,
    input  logic [4:0]        issue_rd,
    output logic              issue_ready,
    input  logic [DATA_W-1:0] done_data,
    input  logic              done_exc,
    input  logic              wb_ready,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_exc,
    output logic              wb_is_div,
    input  logic [4:0]        query_a,
    input  logic [4:0]        query_b,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic              fwd_a_valid,
    output logic              fwd_b_valid,
    output logic [DATA_W-1:0] fwd_a_data,
    output logic [DATA_W-1:0] fwd_b_data,
    output logic              busy
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(STAGES + QDEPTH + 1);

    logic [STAGES-1:0] st_v;
    logic [4:0]        st_rd [STAGES];
    logic [STAGES-1:0] st_div;
    logic [4:0]        q_rd [QDEPTH];
    logic [DATA_W-1:0] q_data [QDEPTH];
    logic [QDEPTH-1:0] q_exc;
    logic [QDEPTH-1:0] q_div;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic [OW-1:0]     inflight;
    logic [DATA_W+1:0] look_a;
    logic [DATA_W+1:0] look_b;
    logic              accept;
    logic              push;
    logic              pop;

    assign accept      = issue_valid & issue_ready & ~flush;
    assign push        = st_v[STAGES-1];
    assign pop         = wb_valid & wb_ready & ~flush;
    assign issue_ready = (inflight + OW'(count)) < OW'(QDEPTH);
    assign busy        = (|st_v) | (count != '0);
    assign wb_valid    = count != '0;
    assign wb_rd       = wb_valid ? q_rd[rptr] : 5'd0;
    assign wb_data     = wb_valid ? q_data[rptr] : '0;
    assign wb_exc      = wb_valid & q_exc[rptr];
    assign wb_is_div   = wb_valid & q_div[rptr];
    assign hazard_a    = look_a[DATA_W+1];
    assign fwd_a_valid = look_a[DATA_W];
    assign fwd_a_data  = look_a[DATA_W-1:0];
    assign hazard_b    = look_b[DATA_W+1];
    assign fwd_b_valid = look_b[DATA_W];
    assign fwd_b_data  = look_b[DATA_W-1:0];

    // returns {hazard, fwd_valid, fwd_data}; stage entries are always younger than queued ones
    function automatic logic [DATA_W+1:0] lookup(input logic [4:0] q);
        logic          st_hit;
        logic          q_hit;
        logic [PW-1:0] idx;
`ifdef MD_SCOREBOARD_FWD_EN
        logic [DATA_W-1:0] q_dat;
        q_dat = '0;
`endif
        st_hit = 1'b0;
        q_hit  = 1'b0;
        for (int i = 0; i < STAGES; i++)
            if (st_v[i] && st_rd[i] == q) st_hit = 1'b1;
        for (int k = 0; k < QDEPTH; k++) begin
            idx = rptr + PW'(k);
            if (CW'(k) < count && q_rd[idx] == q) begin
                q_hit = 1'b1;
`ifdef MD_SCOREBOARD_FWD_EN
                q_dat = q_data[idx];
`endif
            end
        end
        if (q == 5'd0) return '0;
`ifdef MD_SCOREBOARD_FWD_EN
        return {st_hit, ~st_hit & q_hit, st_hit ? DATA_W'(0) : q_dat};
`else
        return {st_hit | q_hit, 1'b0, DATA_W'(0)};
`endif
    endfunction

    // number of ops still travelling through the fixed-latency pipe
    always_comb begin
        inflight = '0;
        for (int i = 0; i < STAGES; i++) inflight = inflight + OW'(st_v[i]);
    end

    // source-register lookups for the decode stage
    always_comb begin
        look_a = lookup(query_a);
        look_b = lookup(query_b);
    end

    // valid bits and queue bookkeeping; reset and flush both empty everything
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            st_v  <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            st_v  <= {st_v[STAGES-2:0], accept};
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // op tags ride along with the valid bits; the pipe never stalls
    always_ff @(posedge clock) begin
        st_rd[0] <= issue_rd;
        for (int i = 1; i < STAGES; i++) st_rd[i] <= st_rd[i-1];
        st_div <= {st_div[STAGES-2:0], issue_is_div};
    end

    // capture the datapath result as the op leaves the final stage
    always_ff @(posedge clock) begin
        if (push) begin
            q_rd[wptr]   <= st_rd[STAGES-1];
            q_data[wptr] <= done_data;
            q_exc[wptr]  <= done_exc;
            q_div[wptr]  <= st_div[STAGES-1];
        end
    end
endmodule
